// File: rtl/linebuf_sched_pkg.sv
// Shared types for the ping-pong line buffer scheduler.
// Holds the render FSM encoding and the overrun counter ceiling.
package linebuf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] OVR_MAX = 8'hFF;

endpackage

// File: rtl/linebuf_sched_if.sv
// Renderer-to-scheduler write request channel.
// The renderer is master; the scheduler returns ready.
interface linebuf_sched_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    modport master (
        output valid, addr, data, done,
        input  ready
    );

    modport slave (
        input  valid, addr, data, done,
        output ready
    );
endinterface

// File: rtl/linebuf_sched.sv
// Ping-pong line buffer sequencer: swaps banks per line and
// arbitrates the single RAM write port between erase and render.
module linebuf_sched
    import linebuf_sched_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_start,
    input  logic                  erase_en,
    input  logic                  scan_valid,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    linebuf_sched_if.slave        rnd,
    output logic                  overrun,
    output logic [7:0]            overrun_cnt,
    output logic                  disp_bank,
    output logic [ADDR_WIDTH:0]   ram_rd_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH:0]   ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
);

    state_t                state_q, state_d;
    logic                  erase_pend;
    logic [ADDR_WIDTH:0]   erase_addr;
    logic                  accept;
    logic                  overrun_d;

    assign ram_rd_addr = {disp_bank, scan_addr};
    assign rnd.ready   = (state_q == ST_RENDER) & ~erase_pend;
    assign accept      = rnd.valid & rnd.ready;
    assign overrun_d   = line_start & (state_q == ST_RENDER);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (line_start) state_d = ST_RENDER;
            // line_start beats render_done: late line counts as overrun
            ST_RENDER: if (!line_start && rnd.done) state_d = ST_DONE;
            ST_DONE:   if (line_start) state_d = ST_RENDER;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            disp_bank   <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state_q <= state_d;
            overrun <= overrun_d;
            if (line_start) disp_bank <= ~disp_bank;
            if (overrun_d && overrun_cnt != OVR_MAX)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // Erase is captured with the read, so it lands after the pixel is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erase_pend <= 1'b0;
            erase_addr <= '0;
        end else begin
            erase_pend <= scan_valid & erase_en;
            erase_addr <= {disp_bank, scan_addr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else if (erase_pend) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= erase_addr;
            ram_wr_data <= CLEAR_VALUE;
        end else if (accept) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= {~disp_bank, rnd.addr};
            ram_wr_data <= rnd.data;
        end else begin
            ram_wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linebuf_sched.sv
// Directed and randomised checks of linebuf_sched against a
// line-level behavioural model of the bank/erase/render rules.
module tb_linebuf_sched;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_start;
    logic          erase_en;
    logic          scan_valid;
    logic [AW-1:0] scan_addr;
    logic          overrun;
    logic [7:0]    overrun_cnt;
    logic          disp_bank;
    logic [AW:0]   ram_rd_addr;
    logic          ram_wr_en;
    logic [AW:0]   ram_wr_addr;
    logic [DW-1:0] ram_wr_data;

    linebuf_sched_if #(.AW(AW), .DW(DW)) rnd ();

    linebuf_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .erase_en   (erase_en),
        .scan_valid (scan_valid),
        .scan_addr  (scan_addr),
        .rnd        (rnd.slave),
        .overrun    (overrun),
        .overrun_cnt(overrun_cnt),
        .disp_bank  (disp_bank),
        .ram_rd_addr(ram_rd_addr),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Line-level model: mode 0=idle 1=rendering 2=finished
    int m_mode, m_bank, m_cnt, m_wa, m_wd;
    bit m_ovr, m_we, m_rdy;
    int m_erq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_bank = 0; m_cnt = 0;
            m_ovr = 0; m_we = 0; m_wa = 0; m_wd = 0;
            m_erq.delete();
        end else begin
            m_rdy = (m_mode == 1) && (m_erq.size() == 0);
            if (m_erq.size() != 0) begin
                m_we = 1; m_wa = m_erq.pop_front(); m_wd = 0;
            end else if (rnd.valid && m_rdy) begin
                m_we = 1;
                m_wa = (1 - m_bank) * 1024 + int'(rnd.addr);
                m_wd = int'(rnd.data);
            end else begin
                m_we = 0;
            end
            if (scan_valid && erase_en)
                m_erq.push_back(m_bank * 1024 + int'(scan_addr));
            m_ovr = line_start && (m_mode == 1);
            if (m_ovr && m_cnt < 255) m_cnt++;
            if (line_start) begin
                m_mode = 1; m_bank = 1 - m_bank;
            end else if (rnd.done && m_mode == 1) begin
                m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("ready", 32'(rnd.ready),
                32'((m_mode == 1) && (m_erq.size() == 0)));
            chk("bank", 32'(disp_bank), 32'(m_bank));
            chk("rd_addr", 32'(ram_rd_addr),
                32'(m_bank * 1024 + int'(scan_addr)));
            chk("ovr", 32'(overrun), 32'(m_ovr));
            chk("ovr_cnt", 32'(overrun_cnt), 32'(m_cnt));
            chk("wr_en", 32'(ram_wr_en), 32'(m_we));
            if (m_we) begin
                chk("wr_addr", 32'(ram_wr_addr), 32'(m_wa));
                chk("wr_data", 32'(ram_wr_data), 32'(m_wd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        line_start = 0; erase_en = 0; scan_valid = 0;
        scan_addr = '0; rnd.valid = 0; rnd.addr = '0;
        rnd.data = '0; rnd.done = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        tick(); tick();
        #1;
        chk("rst_we", 32'(ram_wr_en), 32'h0);
        chk("rst_cnt", 32'(overrun_cnt), 32'h0);
        rst = 1'b0;
        tick();

        // 1: first line_start
        line_start = 1; tick(); line_start = 0;
        chk("t1_bank", 32'(disp_bank), 32'h1);
        chk("t1_ready", 32'(rnd.ready), 32'h1);

        // 2: render write to render bank 0
        rnd.valid = 1; rnd.addr = 10'd5; rnd.data = 8'hA3;
        tick(); rnd.valid = 0;
        chk("t2_we", 32'(ram_wr_en), 32'h1);
        chk("t2_addr", 32'(ram_wr_addr), 32'h005);
        chk("t2_data", 32'(ram_wr_data), 32'hA3);
        tick();

        // 3: erase collides with a held render request
        erase_en = 1; scan_valid = 1; scan_addr = 10'd7;
        rnd.valid = 1; rnd.addr = 10'd9; rnd.data = 8'h5A;
        tick(); scan_valid = 0;
        chk("t3_ready", 32'(rnd.ready), 32'h0);
        tick();
        chk("t3_eaddr", 32'(ram_wr_addr), 32'h407);
        chk("t3_edata", 32'(ram_wr_data), 32'h00);
        tick();
        chk("t3_raddr", 32'(ram_wr_addr), 32'h009);
        chk("t3_rdata", 32'(ram_wr_data), 32'h5A);
        rnd.valid = 0; erase_en = 0;
        tick();

        // 4: overrun
        line_start = 1; tick(); line_start = 0;
        chk("t4_ovr", 32'(overrun), 32'h1);
        chk("t4_cnt", 32'(overrun_cnt), 32'h1);
        chk("t4_bank", 32'(disp_bank), 32'h0);
        tick();
        chk("t4_pulse", 32'(overrun), 32'h0);

        // render_done, then request in DONE is refused
        rnd.done = 1; tick(); rnd.done = 0;
        chk("done_rdy", 32'(rnd.ready), 32'h0);
        rnd.valid = 1; rnd.addr = 10'd2; tick(); rnd.valid = 0;
        chk("done_nowr", 32'(ram_wr_en), 32'h0);
        line_start = 1; tick(); line_start = 0;
        chk("done_noovr", 32'(overrun), 32'h0);
        // line_start together with render_done is an overrun
        line_start = 1; rnd.done = 1; tick();
        line_start = 0; rnd.done = 0;
        chk("both_cnt", 32'(overrun_cnt), 32'h2);
        chk("both_rdy", 32'(rnd.ready), 32'h1);

        // erase captured before a swap goes first
        erase_en = 1; scan_valid = 1; scan_addr = 10'd3;
        line_start = 1; rnd.valid = 1; rnd.addr = 10'd4;
        rnd.data = 8'h11;
        tick(); line_start = 0; scan_valid = 0; erase_en = 0;
        tick(); tick(); rnd.valid = 0; tick();

        // randomised traffic
        for (int i = 0; i < 80; i++) begin
            line_start = ($urandom_range(0, 7) == 0);
            rnd.done   = ($urandom_range(0, 5) == 0);
            erase_en   = 1'($urandom);
            scan_valid = 1'($urandom);
            scan_addr  = 10'($urandom);
            rnd.valid  = 1'($urandom);
            rnd.addr   = 10'($urandom);
            rnd.data   = 8'($urandom);
            tick();
        end
        idle_in();
        tick();

        // 5: saturation
        line_start = 1;
        for (int i = 0; i < 300; i++) tick();
        line_start = 0;
        chk("t5_sat", 32'(overrun_cnt), 32'hFF);
        tick();

        // 6: async reset mid-write
        rnd.valid = 1; rnd.addr = 10'd1; rnd.data = 8'h77;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_we", 32'(ram_wr_en), 32'h0);
        chk("t6_rdy", 32'(rnd.ready), 32'h0);
        chk("t6_bank", 32'(disp_bank), 32'h0);
        chk("t6_cnt", 32'(overrun_cnt), 32'h0);
        idle_in();
        tick();
        rst = 1'b0;
        tick();
        line_start = 1; tick(); line_start = 0;
        chk("t6_restart", 32'(disp_bank), 32'h1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
